// File: rtl/det_arbiter.sv
// det_arbiter: round-robin arbiter feeding two requesters' words serially to a shared 1101 detector
// and counting the matches in each word.
module det_arbiter #(
    parameter int WIDTH = 8,
    parameter int FLUSH = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     req0_valid,
    input  logic                     req1_valid,
    input  logic [WIDTH-1:0]         req0_data,
    input  logic [WIDTH-1:0]         req1_data,
    output logic                     req0_ready,
    output logic                     req1_ready,
    output logic                     det_i,
    input  logic                     det_o,
    output logic                     res_valid,
    output logic                     res_id,
    output logic [$clog2(WIDTH):0]   res_count,
    input  logic                     res_ready
);
    localparam int CW = $clog2(WIDTH + FLUSH + 1);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLUSH, S_RESULT} state_t;
    state_t                r_state, w_next;
    logic [WIDTH-1:0]      r_word;
    logic [CW-1:0]         r_bit;
    logic                  r_last;
    logic                  r_id;
    logic [$clog2(WIDTH):0] r_count;
    logic                  w_g0, w_g1, w_grant, w_shift_end, w_flush_end;
    // r_last holds the last granted requester; the other one wins a contention
    assign w_g0        = req0_valid & (~req1_valid | r_last);
    assign w_g1        = req1_valid & (~req0_valid | ~r_last);
    assign w_grant     = (r_state == S_IDLE) & (w_g0 | w_g1);
    assign w_shift_end = r_bit == CW'(WIDTH - 1);
    assign w_flush_end = r_bit == CW'(WIDTH + FLUSH - 1);
    assign res_id      = r_id;
    assign res_count   = r_count;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_grant ? S_SHIFT : S_IDLE;
            S_SHIFT:  w_next = w_shift_end ? (FLUSH == 0 ? S_RESULT : S_FLUSH) : S_SHIFT;
            S_FLUSH:  w_next = w_flush_end ? S_RESULT : S_FLUSH;
            S_RESULT: w_next = res_ready ? S_IDLE : S_RESULT;
            default:  w_next = S_IDLE;
        endcase
    end
    // readies are held low while reset is asserted, even though the state already reads IDLE
    always_comb begin
        req0_ready = n_rst & (r_state == S_IDLE) & w_g0;
        req1_ready = n_rst & (r_state == S_IDLE) & w_g1;
        det_i      = (r_state == S_SHIFT) & r_word[WIDTH-1];
        res_valid  = r_state == S_RESULT;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_word  <= '0;
            r_bit   <= '0;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_count <= '0;
        end else if (w_grant) begin
            r_word  <= w_g1 ? req1_data : req0_data;
            r_bit   <= '0;
            r_last  <= w_g1;
            r_id    <= w_g1;
            r_count <= '0;
        end else if (r_state == S_SHIFT || r_state == S_FLUSH) begin
            r_bit <= r_bit + CW'(1);
            if (r_state == S_SHIFT) r_word <= r_word << 1;
            if (det_o && !(&r_count)) r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_det_arbiter.sv
// tb_det_arbiter: directed and random transactions checked against a match-counting
// and round-robin reference model; the shared 1101 detector is modelled here.
module tb_det_arbiter;
    localparam int W  = 8;
    localparam int F  = 2;
    localparam int CMAX = (1 << ($clog2(W) + 1)) - 1;
    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         req0_ready, req1_ready;
    logic         det_i, det_o;
    logic         res_valid, res_id;
    logic [$clog2(W):0] res_count;
    logic         res_ready = 1'b0;
    logic [3:0]   r_hist;
    int           checks = 0;
    int           failures = 0;
    logic         rr_last = 1'b1;
    always #5 clk = ~clk;
    det_arbiter #(.WIDTH(W), .FLUSH(F)) dut (
        .clk(clk), .n_rst(n_rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .det_i(det_i), .det_o(det_o),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
        .res_ready(res_ready)
    );
    // Moore 1101 detector: flag is high the cycle after the completing bit
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_hist <= '0;
        else        r_hist <= {r_hist[2:0], det_i};
    end
    assign det_o = r_hist == 4'b1101;
    function automatic int ref_count(input logic [W-1:0] w);
        int n = 0;
        for (int i = W - 1; i >= 3; i--) if (w[i -: 4] == 4'b1101) n++;
        return n > CMAX ? CMAX : n;
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic txn(input logic v0, input logic v1, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input int hold);
        logic         eid;
        logic [W-1:0] w;
        int           ec;
        @(negedge clk);
        req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1; res_ready = 1'b0;
        #1;
        eid = (v0 && v1) ? ~rr_last : v1;
        check("ready0", req0_ready, !eid);
        check("ready1", req1_ready, eid);
        rr_last = eid;
        w  = eid ? d1 : d0;
        ec = ref_count(w);
        for (int i = 0; i < W + F; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req0_data = W'($urandom);
                req1_data = W'($urandom);
            end
            check("det_i", det_i, i < W ? w[W-1-i] : 1'b0);
            check("busy_ready", req0_ready | req1_ready, 0);
            check("early_res_valid", res_valid, 0);
        end
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            check("res_valid", res_valid, 1);
            check("res_id", res_id, eid);
            check("res_count", res_count, ec);
            check("result_ready", req0_ready | req1_ready, 0);
            check("result_det_i", det_i, 0);
        end
        res_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        check("released", res_valid, 0);
    endtask
    initial begin
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h0D; req1_data = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_det_i", det_i, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_count", res_count, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_rst = 1'b1;
        txn(1, 1, 8'h0D, 8'hFF, 0);
        txn(1, 1, 8'h0D, 8'hFF, 0);
        txn(1, 1, 8'h0D, 8'hFF, 0);
        txn(1, 0, 8'hD0, 8'h00, 0);
        txn(0, 1, 8'h00, 8'hDB, 5);
        // abort a word with reset in its 4th shift cycle
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 8'hDD;
        #1;
        check("abort_grant", req1_ready, 1);
        repeat (4) @(negedge clk);
        check("abort_det_i_pre", det_i, 1);
        #2 n_rst = 1'b0;
        #1;
        check("abort_det_i", det_i, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_res_id", res_id, 0);
        check("abort_res_count", res_count, 0);
        check("abort_ready1", req1_ready, 0);
        rr_last = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        n_rst = 1'b1;
        for (int i = 0; i < W + F + 2; i++) begin
            @(negedge clk);
            check("abort_no_result", res_valid, 0);
        end
        txn(1, 0, 8'hD0, 8'h00, 0);
        txn(1, 1, 8'h00, 8'hF0, 1);
        txn(1, 0, 8'h0D, 8'h00, 0);
        for (int k = 0; k < 40; k++) begin
            logic a, b;
            a = 1'($urandom_range(0, 1));
            b = a ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(a, b, W'($urandom), W'($urandom), $urandom_range(0, 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
